rob_multi: RTL and testbench

Parametrised successor to the single-issue reorder buffer for the write-back stage. It accepts up to two in-order dispatches per cycle and takes completions on WB_PORTS independent write-back ports. It retires up to two finished entries per cycle in program order. It also adds per-entry exception tracking, a flush, and an occupancy count.

---
 rtl/rob_multi_if.sv | 44 ++++
 rtl/rob_multi.sv | 134 +++++++++++++
 tb/tb_rob_multi.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rob_multi_if.sv
// Dispatch, write-back, commit and status signals of the multi-issue reorder buffer.
// master = dispatch/control side, slave = the reorder buffer itself.
interface rob_multi_if #(
    parameter int ROB_ADDR_SIZE  = 5,
    parameter int DEST_ADDR_SIZE = 4,
    parameter int INS_TYPE_SIZE  = 2,
    parameter int WB_PORTS       = 2
);
    // dispatch
    logic [1:0]                          alloc_valid;
    logic [2*DEST_ADDR_SIZE-1:0]         alloc_dest;
    logic [2*INS_TYPE_SIZE-1:0]          alloc_type;
    logic [1:0]                          alloc_ready;
    logic [2*ROB_ADDR_SIZE-1:0]          alloc_id;
    // write-back
    logic [WB_PORTS-1:0]                 wb_valid;
    logic [WB_PORTS*ROB_ADDR_SIZE-1:0]   wb_rob_id;
    logic [WB_PORTS-1:0]                 wb_exc;
    // commit
    logic [1:0]                          commit_valid;
    logic [1:0]                          commit_en;
    logic [2*DEST_ADDR_SIZE-1:0]         commit_dest;
    logic [2*INS_TYPE_SIZE-1:0]          commit_type;
    logic                                head_exception;
    // control / status
    logic                                flush;
    logic [ROB_ADDR_SIZE:0]              count;
    logic                                empty;
    logic                                full;

    modport master (
        output alloc_valid, alloc_dest, alloc_type, wb_valid, wb_rob_id, wb_exc,
               commit_en, flush,
        input  alloc_ready, alloc_id, commit_valid, commit_dest, commit_type,
               head_exception, count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_dest, alloc_type, wb_valid, wb_rob_id, wb_exc,
               commit_en, flush,
        output alloc_ready, alloc_id, commit_valid, commit_dest, commit_type,
               head_exception, count, empty, full
    );
endinterface

// File: rtl/rob_multi.sv
// Dual-dispatch, dual-retire reorder buffer with WB_PORTS completion ports,
// per-entry exception flag, flush and occupancy count.
module rob_multi #(
    parameter int ROB_ADDR_SIZE  = 5,
    parameter int DEST_ADDR_SIZE = 4,
    parameter int INS_TYPE_SIZE  = 2,
    parameter int WB_PORTS       = 2
) (
    input  logic         clk,
    input  logic         reset,
    rob_multi_if.slave   bus
);
    localparam int ROB_SIZE = 1 << ROB_ADDR_SIZE;

    typedef logic [ROB_ADDR_SIZE-1:0] ptr_t;
    typedef logic [ROB_ADDR_SIZE:0]   cnt_t;

    // entry storage
    logic [ROB_SIZE-1:0]       valid;
    logic [ROB_SIZE-1:0]       finished;
    logic [ROB_SIZE-1:0]       exc;
    logic [DEST_ADDR_SIZE-1:0] dest  [ROB_SIZE];
    logic [INS_TYPE_SIZE-1:0]  itype [ROB_SIZE];

    ptr_t head, tail, head_next1, tail_next1;
    cnt_t count;

    logic [1:0]          ready, cvalid;
    logic                accept0, accept1, commit0, commit1;
    logic [ROB_SIZE-1:0] retirable;
    logic [ROB_SIZE-1:0] wr0_mask, wr1_mask, clr_mask;
    logic [ROB_SIZE-1:0] wb_hit, wb_exc_or;

    assign head_next1 = head + ptr_t'(1);
    assign tail_next1 = tail + ptr_t'(1);

    // Readiness comes from the registered count only, so a same-cycle
    // commit never frees room for a same-cycle allocation.
    assign ready[0] = count < cnt_t'(ROB_SIZE);
    assign ready[1] = count < cnt_t'(ROB_SIZE - 1);

    assign retirable = valid & finished & ~exc;
    assign cvalid[0] = retirable[head];
    assign cvalid[1] = cvalid[0] & retirable[head_next1];

    // lane1 is only honoured together with lane0 (thermometer handshakes)
    assign accept0 = bus.alloc_valid[0] & ready[0];
    assign accept1 = accept0 & bus.alloc_valid[1] & ready[1];
    assign commit0 = bus.commit_en[0] & cvalid[0];
    assign commit1 = commit0 & bus.commit_en[1] & cvalid[1];

    // decode allocation and retirement targets into one-hot entry masks
    always_comb begin
        wr0_mask = '0;
        wr1_mask = '0;
        clr_mask = '0;
        if (accept0) wr0_mask[tail]       = 1'b1;
        if (accept1) wr1_mask[tail_next1] = 1'b1;
        if (commit0) clr_mask[head]       = 1'b1;
        if (commit1) clr_mask[head_next1] = 1'b1;
    end

    // merge all write-back ports per entry; colliding ports OR their exceptions
    always_comb begin
        wb_hit    = '0;
        wb_exc_or = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (bus.wb_valid[p]) begin
                wb_hit[bus.wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE]] = 1'b1;
                if (bus.wb_exc[p])
                    wb_exc_or[bus.wb_rob_id[p*ROB_ADDR_SIZE +: ROB_ADDR_SIZE]] = 1'b1;
            end
        end
    end

    // pointers and occupancy; flush outranks every other update
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(commit0) + ptr_t'(commit1);
            tail  <= tail + ptr_t'(accept0) + ptr_t'(accept1);
            count <= count + cnt_t'(accept0) + cnt_t'(accept1)
                           - cnt_t'(commit0) - cnt_t'(commit1);
        end
    end

    // entry fields: allocation initialises, retirement invalidates,
    // write-back only lands on entries that are currently valid
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= '0;
            finished <= '0;
            exc      <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                dest[i]  <= '0;
                itype[i] <= '0;
            end
        end else if (bus.flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (wr0_mask[i] || wr1_mask[i]) begin
                    valid[i]    <= 1'b1;
                    finished[i] <= 1'b0;
                    exc[i]      <= 1'b0;
                    dest[i]     <= wr0_mask[i] ? bus.alloc_dest[0 +: DEST_ADDR_SIZE]
                                               : bus.alloc_dest[DEST_ADDR_SIZE +: DEST_ADDR_SIZE];
                    itype[i]    <= wr0_mask[i] ? bus.alloc_type[0 +: INS_TYPE_SIZE]
                                               : bus.alloc_type[INS_TYPE_SIZE +: INS_TYPE_SIZE];
                end else begin
                    if (clr_mask[i])
                        valid[i] <= 1'b0;
                    if (wb_hit[i] && valid[i]) begin
                        finished[i] <= 1'b1;
                        exc[i]      <= exc[i] | wb_exc_or[i];
                    end
                end
            end
        end
    end

    assign bus.alloc_ready    = ready;
    assign bus.alloc_id       = {tail_next1, tail};
    assign bus.commit_valid   = cvalid;
    assign bus.commit_dest    = {dest[head_next1], dest[head]};
    assign bus.commit_type    = {itype[head_next1], itype[head]};
    assign bus.head_exception = valid[head] & finished[head] & exc[head];
    assign bus.count          = count;
    assign bus.empty          = count == '0;
    assign bus.full           = count == cnt_t'(ROB_SIZE);
endmodule

// File: tb/tb_rob_multi.sv
// Directed vector table plus hand-written fill / wrap / boundary sequences for rob_multi.
module tb_rob_multi;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    rob_multi_if #(.ROB_ADDR_SIZE(5), .DEST_ADDR_SIZE(4), .INS_TYPE_SIZE(2), .WB_PORTS(2)) bus();

    rob_multi #(.ROB_ADDR_SIZE(5), .DEST_ADDR_SIZE(4), .INS_TYPE_SIZE(2), .WB_PORTS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] av;   logic [7:0] ad;  logic [3:0] at;
        logic [1:0] wv;   logic [9:0] wid; logic [1:0] we;
        logic [1:0] ce;   logic       fl;
        logic [5:0] e_count; logic [1:0] e_ready; logic [9:0] e_id;
        logic [1:0] e_cv;    logic [7:0] e_cdest; logic       e_hexc;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid = '0; bus.alloc_dest = '0; bus.alloc_type = '0;
        bus.wb_valid = '0; bus.wb_rob_id = '0; bus.wb_exc = '0;
        bus.commit_en = '0; bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic fill31();
        for (int k = 0; k < 15; k++) begin
            bus.alloc_valid = 2'b11;
            bus.alloc_dest  = {4'(2*k+1), 4'(2*k)};
            tick();
        end
        bus.alloc_valid = 2'b01;
        bus.alloc_dest  = 8'h0E;
        tick();
        idle();
    endtask

    initial begin
        idle();
        do_reset();

        // reset state
        check("rst count", 32'(bus.count), 32'd0);
        check("rst empty", 32'(bus.empty), 32'd1);
        check("rst full", 32'(bus.full), 32'd0);
        check("rst ready", 32'(bus.alloc_ready), 32'd3);
        check("rst id", 32'(bus.alloc_id), 32'({5'd1, 5'd0}));
        check("rst cv", 32'(bus.commit_valid), 32'd0);
        check("rst hexc", 32'(bus.head_exception), 32'd0);

        //          av     ad              at    wv     wid              we     ce     fl    cnt   rdy    id               cv     cdest           hexc
        vecs[0]  = '{2'b11, {4'd2, 4'd1},   4'h4, 2'b00, 10'd0,           2'b00, 2'b00, 1'b0, 6'd2, 2'b11, {5'd3, 5'd2},   2'b00, {4'd2, 4'd1},   1'b0};
        vecs[1]  = '{2'b11, {4'd4, 4'd3},   4'h0, 2'b00, 10'd0,           2'b00, 2'b00, 1'b0, 6'd4, 2'b11, {5'd5, 5'd4},   2'b00, {4'd2, 4'd1},   1'b0};
        vecs[2]  = '{2'b00, 8'd0,           4'h0, 2'b11, {5'd0, 5'd1},    2'b00, 2'b00, 1'b0, 6'd4, 2'b11, {5'd5, 5'd4},   2'b11, {4'd2, 4'd1},   1'b0};
        vecs[3]  = '{2'b00, 8'd0,           4'h0, 2'b00, 10'd0,           2'b00, 2'b11, 1'b0, 6'd2, 2'b11, {5'd5, 5'd4},   2'b00, {4'd4, 4'd3},   1'b0};
        vecs[4]  = '{2'b00, 8'd0,           4'h0, 2'b11, {5'd3, 5'd3},    2'b10, 2'b00, 1'b0, 6'd2, 2'b11, {5'd5, 5'd4},   2'b00, {4'd4, 4'd3},   1'b0};
        vecs[5]  = '{2'b00, 8'd0,           4'h0, 2'b01, {5'd0, 5'd2},    2'b00, 2'b00, 1'b0, 6'd2, 2'b11, {5'd5, 5'd4},   2'b01, {4'd4, 4'd3},   1'b0};
        vecs[6]  = '{2'b00, 8'd0,           4'h0, 2'b00, 10'd0,           2'b00, 2'b01, 1'b0, 6'd1, 2'b11, {5'd5, 5'd4},   2'b00, {4'd0, 4'd4},   1'b1};
        vecs[7]  = '{2'b00, 8'd0,           4'h0, 2'b01, {5'd0, 5'd9},    2'b01, 2'b00, 1'b0, 6'd1, 2'b11, {5'd5, 5'd4},   2'b00, {4'd0, 4'd4},   1'b1};
        vecs[8]  = '{2'b11, {4'hF, 4'hE},   4'h0, 2'b01, {5'd0, 5'd3},    2'b00, 2'b00, 1'b1, 6'd0, 2'b11, {5'd1, 5'd0},   2'b00, {4'd2, 4'd1},   1'b0};
        vecs[9]  = '{2'b00, 8'd0,           4'h0, 2'b00, 10'd0,           2'b00, 2'b11, 1'b0, 6'd0, 2'b11, {5'd1, 5'd0},   2'b00, {4'd2, 4'd1},   1'b0};
        vecs[10] = '{2'b10, {4'd7, 4'd6},   4'h0, 2'b00, 10'd0,           2'b00, 2'b00, 1'b0, 6'd0, 2'b11, {5'd1, 5'd0},   2'b00, {4'd2, 4'd1},   1'b0};

        for (int i = 0; i < 11; i++) begin
            bus.alloc_valid = vecs[i].av; bus.alloc_dest = vecs[i].ad; bus.alloc_type = vecs[i].at;
            bus.wb_valid = vecs[i].wv; bus.wb_rob_id = vecs[i].wid; bus.wb_exc = vecs[i].we;
            bus.commit_en = vecs[i].ce; bus.flush = vecs[i].fl;
            tick();
            idle();
            check($sformatf("v%0d count", i), 32'(bus.count), 32'(vecs[i].e_count));
            check($sformatf("v%0d ready", i), 32'(bus.alloc_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d id", i), 32'(bus.alloc_id), 32'(vecs[i].e_id));
            check($sformatf("v%0d cv", i), 32'(bus.commit_valid), 32'(vecs[i].e_cv));
            check($sformatf("v%0d cdest", i), 32'(bus.commit_dest), 32'(vecs[i].e_cdest));
            check($sformatf("v%0d hexc", i), 32'(bus.head_exception), 32'(vecs[i].e_hexc));
            check($sformatf("v%0d empty", i), 32'(bus.empty), 32'(vecs[i].e_count == 6'd0));
        end

        // dual allocation every cycle until full
        do_reset();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("fill id%0d", k), 32'(bus.alloc_id), 32'({5'(2*k+1), 5'(2*k)}));
            bus.alloc_valid = 2'b11;
            tick();
        end
        idle();
        check("fill count", 32'(bus.count), 32'd32);
        check("fill full", 32'(bus.full), 32'd1);
        check("fill ready", 32'(bus.alloc_ready), 32'd0);
        bus.alloc_valid = 2'b11;
        tick();
        idle();
        check("full hold count", 32'(bus.count), 32'd32);
        check("full hold id", 32'(bus.alloc_id), 32'({5'd1, 5'd0}));

        // count 31: only lane0 may go; alloc+commit keeps count at 31
        do_reset();
        fill31();
        check("c31 count", 32'(bus.count), 32'd31);
        check("c31 ready", 32'(bus.alloc_ready), 32'd1);
        check("c31 id", 32'(bus.alloc_id), 32'({5'd0, 5'd31}));
        bus.wb_valid = 2'b01; bus.wb_rob_id = {5'd0, 5'd0};
        tick();
        idle();
        check("c31 cv", 32'(bus.commit_valid), 32'd1);
        bus.alloc_valid = 2'b11; bus.commit_en = 2'b01;
        tick();
        idle();
        check("c31 ac count", 32'(bus.count), 32'd31);
        check("c31 ac ready", 32'(bus.alloc_ready), 32'd1);
        check("c31 ac id", 32'(bus.alloc_id), 32'({5'd1, 5'd0}));
        bus.alloc_valid = 2'b11;
        tick();
        idle();
        check("c31 last count", 32'(bus.count), 32'd32);
        check("c31 last full", 32'(bus.full), 32'd1);

        // wrap-around: tail 31, dual alloc with dual commit
        do_reset();
        fill31();
        bus.wb_valid = 2'b11; bus.wb_rob_id = {5'd1, 5'd0};
        tick();
        idle();
        bus.commit_en = 2'b11;
        tick();
        idle();
        check("wrap pre count", 32'(bus.count), 32'd29);
        check("wrap pre ready", 32'(bus.alloc_ready), 32'd3);
        bus.wb_valid = 2'b11; bus.wb_rob_id = {5'd3, 5'd2};
        tick();
        idle();
        check("wrap cv", 32'(bus.commit_valid), 32'd3);
        check("wrap id", 32'(bus.alloc_id), 32'({5'd0, 5'd31}));
        bus.alloc_valid = 2'b11; bus.alloc_dest = {4'h5, 4'hA}; bus.commit_en = 2'b11;
        tick();
        idle();
        check("wrap count", 32'(bus.count), 32'd29);
        check("wrap tail", 32'(bus.alloc_id), 32'({5'd2, 5'd1}));
        for (int id = 4; id <= 30; id += 2) begin
            bus.wb_valid = 2'b11; bus.wb_rob_id = {5'(id + 1), 5'(id)};
            tick();
        end
        bus.wb_valid = 2'b01; bus.wb_rob_id = {5'd0, 5'd0};
        tick();
        idle();
        bus.commit_en = 2'b01;
        tick();
        idle();
        for (int j = 0; j < 13; j++) begin
            check($sformatf("drain cv%0d", j), 32'(bus.commit_valid), 32'd3);
            bus.commit_en = 2'b11;
            tick();
            idle();
        end
        check("wrap head cv", 32'(bus.commit_valid), 32'd3);
        check("wrap head dest", 32'(bus.commit_dest), 32'({4'h5, 4'hA}));
        check("wrap head count", 32'(bus.count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
